// File: rtl/serial_add_if.sv
// serial_add_if: word-level request/response bundle between a requester
// (master) and the serial_add_sequencer (slave).
// The subtract-select line only exists when SERIAL_ADD_SUBTRACT_EN is defined.
interface serial_add_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
`ifdef SERIAL_ADD_SUBTRACT_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;

`ifdef SERIAL_ADD_SUBTRACT_EN
    modport master (
        output start, op_a, op_b, sub,
        input  busy, done, result, carry_out
    );

    modport slave (
        input  start, op_a, op_b, sub,
        output busy, done, result, carry_out
    );
`else
    modport master (
        output start, op_a, op_b,
        input  busy, done, result, carry_out
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, result, carry_out
    );
`endif
endinterface

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: builds a W-bit ripple adder over time out of one
// clocked 1-bit full-adder cell with a fixed latency of LAT cycles.
// Operands are shifted out LSB-first on fa_a/fa_b, the carry register drives
// fa_cin, and each captured fa_cout becomes the next bit's carry-in.
// Optional feature macro: SERIAL_ADD_SUBTRACT_EN adds the sub select
// (A - B computed as A + ~B + 1, carry_out then means "no borrow").
module serial_add_sequencer #(
    parameter int W   = 8,
    parameter int LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_add_if.slave    bus,
    output logic           fa_a,
    output logic           fa_b,
    output logic           fa_cin,
    input  logic           fa_sum,
    input  logic           fa_cout
);
    localparam int IW = $clog2(W);
    localparam int CW = $clog2(LAT + 1);

    localparam logic [IW-1:0] LAST_BIT  = IW'(W - 1);
    localparam logic [CW-1:0] WAIT_ONE  = CW'(1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t        state_reg;
    logic [W-1:0]  a_shift_reg;
    logic [W-1:0]  b_shift_reg;
    logic          carry_reg;
    logic [IW-1:0] bit_idx_reg;
    logic [CW-1:0] wait_cnt_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [W-1:0]  result_reg;
    logic          carry_out_reg;

    // Operand-B image and initial carry loaded on acceptance. For subtraction
    // B is inverted once at load time so the shift register already holds ~B.
    logic [W-1:0]  b_load;
    logic          carry_init;

`ifdef SERIAL_ADD_SUBTRACT_EN
    assign b_load     = bus.sub ? ~bus.op_b : bus.op_b;
    assign carry_init = bus.sub;
`else
    assign b_load     = bus.op_b;
    assign carry_init = 1'b0;
`endif

    // Sequencer FSM: loads operands, paces one bit per LAT+1 cycles and
    // assembles the result. The shift registers shift in zeros, so after the
    // last bit fa_a/fa_b fall to 0 by themselves; the carry register is
    // cleared explicitly when entering DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            a_shift_reg   <= '0;
            b_shift_reg   <= '0;
            carry_reg     <= 1'b0;
            bit_idx_reg   <= '0;
            wait_cnt_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        a_shift_reg  <= bus.op_a;
                        b_shift_reg  <= b_load;
                        carry_reg    <= carry_init;
                        bit_idx_reg  <= '0;
                        wait_cnt_reg <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // The ISSUE cycle itself is the first of LAT cycles the
                    // adder needs before its outputs are valid.
                    wait_cnt_reg <= WAIT_ONE;
                    state_reg    <= (LAT == 1) ? S_CAPTURE : S_WAIT;
                end

                S_WAIT: begin
                    if (wait_cnt_reg == WAIT_LAST) begin
                        state_reg <= S_CAPTURE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_ONE;
                    end
                end

                S_CAPTURE: begin
                    // Sum bits enter at the top; after W captures bit 0 of
                    // the result has reached the LSB position.
                    result_reg  <= {fa_sum, result_reg[W-1:1]};
                    a_shift_reg <= a_shift_reg >> 1;
                    b_shift_reg <= b_shift_reg >> 1;
                    if (bit_idx_reg == LAST_BIT) begin
                        carry_out_reg <= fa_cout;
                        carry_reg     <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= S_DONE;
                    end else begin
                        carry_reg   <= fa_cout;
                        bit_idx_reg <= bit_idx_reg + 1'b1;
                        state_reg   <= S_ISSUE;
                    end
                end

                S_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign fa_a          = a_shift_reg[0];
    assign fa_b          = b_shift_reg[0];
    assign fa_cin        = carry_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.result    = result_reg;
    assign bus.carry_out = carry_out_reg;
endmodule
